// File: rtl/conway_pkg.sv
// Shared types and width helpers for the Game-of-Life frame reader.
// Imported by the reader top, its interface and the hold-off timer.
package conway_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_SEND,
    S_STEP,
    S_WAIT
  } reader_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int d);
    return (d > 0) ? $clog2(d + 1) : 1;
  endfunction

endpackage

// File: rtl/conway_frame_reader_if.sv
// Row stream from the frame reader to the display driver.
// Plain valid/ready; row_data and row_addr travel together.
interface conway_frame_reader_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  import conway_pkg::*;

  localparam int IW = idx_w(ROWS);

  logic [COLS-1:0] row_data;
  logic [IW-1:0]   row_addr;
  logic            row_valid;
  logic            row_ready;

  modport master (
    output row_data,
    output row_addr,
    output row_valid,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_addr,
    input  row_valid,
    output row_ready
  );

endinterface

// File: rtl/conway_holdoff_timer.sv
// Load/decrement down counter timing the gap between a
// generation step and the next board snapshot.
module conway_holdoff_timer
  import conway_pkg::*;
#(
  parameter int GEN_DELAY = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last,
  output logic zero
);

  localparam int CW = cnt_w(GEN_DELAY);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CW'(GEN_DELAY);
    end else if (dec && !zero) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == CW'(1));

endmodule

// File: rtl/conway_frame_reader.sv
// Snapshots the cell board, streams it row by row, then pulses
// gen_ena to advance every cell and waits out the hold-off.
module conway_frame_reader
  import conway_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int GEN_DELAY = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ROWS*COLS-1:0] board_q,
  conway_frame_reader_if.master rows,
  output logic                 gen_ena,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int IW = idx_w(ROWS);
  localparam logic [IW-1:0] LAST_ROW = IW'(ROWS - 1);

  reader_state_t        state_q;
  reader_state_t        state_d;
  logic [IW-1:0]        row_idx;
  logic [ROWS*COLS-1:0] snapshot;
  logic                 xfer;
  logic                 last_row;
  logic                 t_load;
  logic                 t_dec;
  logic                 t_last;
  logic                 t_zero;

  assign xfer     = (state_q == S_SEND) & rows.row_ready;
  assign last_row = (row_idx == LAST_ROW);

  conway_holdoff_timer #(
    .GEN_DELAY (GEN_DELAY)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .dec  (t_dec),
    .last (t_last),
    .zero (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= '0;
      row_idx  <= '0;
    end else if (state_q == S_SNAP) begin
      snapshot <= board_q;
      row_idx  <= '0;
    end else if (xfer && !last_row) begin
      row_idx <= row_idx + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    t_load         = 1'b0;
    t_dec          = 1'b0;
    gen_ena        = 1'b0;
    frame_done     = 1'b0;
    busy           = (state_q != S_IDLE);
    rows.row_valid = 1'b0;
    rows.row_addr  = '0;
    rows.row_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_SNAP;
      end
      S_SNAP: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        rows.row_valid = 1'b1;
        rows.row_addr  = row_idx;
        rows.row_data  =
          snapshot[int'(row_idx)*COLS +: COLS];
        if (xfer && last_row) state_d = S_STEP;
      end
      S_STEP: begin
        gen_ena    = 1'b1;
        frame_done = 1'b1;
        t_load     = 1'b1;
        // with no hold-off the run decision is taken here
        if (GEN_DELAY == 0) begin
          state_d = run ? S_SNAP : S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        t_dec = 1'b1;
        if (t_last || t_zero) begin
          state_d = run ? S_SNAP : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conway_frame_reader.sv
// Scenario bench for the frame reader: 4x4 board, hold-off 2,
// plus a zero hold-off instance for the cadence check.
module tb_conway_frame_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        run2;
  logic [15:0] board;
  logic        gen_ena, frame_done, busy;
  logic        gen2, fd2, busy2;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] q[$];

  always #5 clk = ~clk;

  conway_frame_reader_if #(.ROWS(4), .COLS(4)) rif ();
  conway_frame_reader_if #(.ROWS(4), .COLS(4)) rif2 ();

  conway_frame_reader #(
    .ROWS(4), .COLS(4), .GEN_DELAY(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .board_q    (board),
    .rows       (rif),
    .gen_ena    (gen_ena),
    .frame_done (frame_done),
    .busy       (busy)
  );

  conway_frame_reader #(
    .ROWS(4), .COLS(4), .GEN_DELAY(0)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .run        (run2),
    .board_q    (board),
    .rows       (rif2),
    .gen_ena    (gen2),
    .frame_done (fd2),
    .busy       (busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    run = 1'b0;
    run2 = 1'b0;
    rif.row_ready = 1'b1;
    rif2.row_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic push_frame(input logic [15:0] b);
    for (int r = 0; r < 4; r++)
      q.push_back({2'(r), b[r*4 +: 4]});
  endtask

  function automatic logic [5:0] pop_exp();
    if (q.size() == 0) return 6'bx;
    return q.pop_front();
  endfunction

  task automatic test_reset;
    logic [9:0] got;
    do_reset();
    got = {rif.row_valid, gen_ena, frame_done, busy,
           rif.row_addr, rif.row_data};
    n_cmp++;
    if (got !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outputs got %h exp 000", got);
    end
  endtask

  task automatic test_basic;
    int first, g;
    logic [5:0] e;
    logic [3:0] exp_t [1:4];
    logic [3:0] got;
    do_reset();
    board = 16'hA5C3;
    push_frame(board);
    run = 1'b1;
    first = 0;
    g = 0;
    for (int c = 1; c <= 40 && g == 0; c++) begin
      tick();
      if (rif.row_valid && rif.row_ready) begin
        if (first == 0) first = c;
        e = pop_exp();
        n_cmp++;
        if ({rif.row_addr, rif.row_data} !== e) begin
          n_err++;
          $display("FAIL basic_row got %h exp %h",
                   {rif.row_addr, rif.row_data}, e);
        end
      end
      n_cmp++;
      if (gen_ena !== frame_done) begin
        n_err++;
        $display("FAIL basic_pulse_align gen %b done %b",
                 gen_ena, frame_done);
      end
      if (gen_ena === 1'b1) g = c;
    end
    n_cmp++;
    if (g == 0 || g != first + 4 || q.size() != 0) begin
      n_err++;
      $display("FAIL basic_timing gen %0d exp %0d left %0d",
               g, first + 4, q.size());
    end
    // {valid, busy, gen_ena, frame_done} per cycle after gen_ena
    exp_t[1] = 4'b0100;
    exp_t[2] = 4'b0100;
    exp_t[3] = 4'b0100;
    exp_t[4] = 4'b1100;
    for (int k = 1; k <= 4; k++) begin
      tick();
      got = {rif.row_valid, busy, gen_ena, frame_done};
      n_cmp++;
      if (got !== exp_t[k]) begin
        n_err++;
        $display("FAIL basic_holdoff k%0d got %b exp %b",
                 k, got, exp_t[k]);
      end
    end
    n_cmp++;
    if (rif.row_addr !== 2'd0) begin
      n_err++;
      $display("FAIL basic_next_addr got %0d exp 0",
               rif.row_addr);
    end
  endtask

  task automatic test_backpressure;
    int stall, rise, g;
    bit done_stall, seen2;
    logic [5:0] e;
    do_reset();
    board = 16'hA5C3;
    push_frame(board);
    run = 1'b1;
    stall = 0;
    rise = 0;
    g = 0;
    done_stall = 0;
    seen2 = 0;
    for (int c = 1; c <= 50 && g == 0; c++) begin
      tick();
      if (!done_stall &&
          (stall > 0 || (rif.row_valid && rif.row_addr == 1))) begin
        if (stall < 5) begin
          rif.row_ready = 1'b0;
          n_cmp++;
          if ({rif.row_valid, rif.row_addr, rif.row_data} !==
              {1'b1, 2'd1, board[7:4]}) begin
            n_err++;
            $display("FAIL bp_hold got %b/%0d/%h exp 1/1/%h",
                     rif.row_valid, rif.row_addr, rif.row_data,
                     board[7:4]);
          end
          stall++;
        end else begin
          rif.row_ready = 1'b1;
          done_stall = 1;
          rise = c;
        end
      end
      if (rif.row_valid && rif.row_ready) begin
        if (rif.row_addr == 2'd2 && !seen2) begin
          seen2 = 1;
          n_cmp++;
          if (c != rise + 1) begin
            n_err++;
            $display("FAIL bp_row2_cycle got %0d exp %0d",
                     c, rise + 1);
          end
        end
        e = pop_exp();
        n_cmp++;
        if ({rif.row_addr, rif.row_data} !== e) begin
          n_err++;
          $display("FAIL bp_row got %h exp %h",
                   {rif.row_addr, rif.row_data}, e);
        end
      end
      if (gen_ena === 1'b1) g = c;
    end
    n_cmp++;
    if (g == 0 || !seen2 || q.size() != 0) begin
      n_err++;
      $display("FAIL bp_complete gen %0d seen2 %0d left %0d",
               g, seen2, q.size());
    end
  endtask

  task automatic test_coherence;
    int gens;
    bit changed;
    logic [5:0] e;
    do_reset();
    board = 16'hA5C3;
    push_frame(16'hA5C3);
    push_frame(16'hFFFF);
    run = 1'b1;
    gens = 0;
    changed = 0;
    for (int c = 1; c <= 60 && gens < 2; c++) begin
      tick();
      if (rif.row_valid && !changed) begin
        board = 16'hFFFF;
        changed = 1;
      end
      if (rif.row_valid && rif.row_ready) begin
        e = pop_exp();
        n_cmp++;
        if ({rif.row_addr, rif.row_data} !== e) begin
          n_err++;
          $display("FAIL coh_row got %h exp %h",
                   {rif.row_addr, rif.row_data}, e);
        end
      end
      if (gen_ena === 1'b1) gens++;
    end
    n_cmp++;
    if (gens != 2 || q.size() != 0) begin
      n_err++;
      $display("FAIL coh_frames gens %0d exp 2 left %0d",
               gens, q.size());
    end
  endtask

  task automatic test_run_drop;
    int gens, g, after;
    logic b2, b3;
    logic [5:0] e;
    do_reset();
    board = 16'hA5C3;
    push_frame(board);
    run = 1'b1;
    gens = 0;
    g = 0;
    after = 0;
    b2 = 1'b0;
    b3 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rif.row_valid && rif.row_addr == 2 && run)
        run = 1'b0;
      if (gens > 0 && rif.row_valid) after++;
      if (rif.row_valid && rif.row_ready) begin
        e = pop_exp();
        n_cmp++;
        if ({rif.row_addr, rif.row_data} !== e) begin
          n_err++;
          $display("FAIL drop_row got %h exp %h",
                   {rif.row_addr, rif.row_data}, e);
        end
      end
      if (g > 0 && c == g + 2) b2 = busy;
      if (g > 0 && c == g + 3) b3 = busy;
      if (gen_ena === 1'b1) begin
        gens++;
        g = c;
      end
    end
    n_cmp++;
    if (gens != 1 || q.size() != 0 || after != 0) begin
      n_err++;
      $display("FAIL drop_frame gens %0d left %0d extra %0d",
               gens, q.size(), after);
    end
    n_cmp++;
    if ({b2, b3, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL drop_idle busy got %b exp 100",
               {b2, b3, busy});
    end
  endtask

  task automatic test_reset_mid;
    int g;
    bit fired;
    logic [9:0] got;
    logic [5:0] e;
    do_reset();
    board = 16'hA5C3;
    push_frame(board);
    run = 1'b1;
    fired = 0;
    for (int c = 1; c <= 20 && !fired; c++) begin
      tick();
      if (rif.row_valid && rif.row_addr == 1) begin
        rst = 1'b1;
        fired = 1;
      end
    end
    tick();
    got = {rif.row_valid, gen_ena, frame_done, busy,
           rif.row_addr, rif.row_data};
    n_cmp++;
    if (!fired || got !== 10'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs fired %0d got %h exp 000",
               fired, got);
    end
    rst = 1'b0;
    q.delete();
    push_frame(board);
    g = 0;
    for (int c = 1; c <= 30 && g == 0; c++) begin
      tick();
      if (rif.row_valid && rif.row_ready) begin
        e = pop_exp();
        n_cmp++;
        if ({rif.row_addr, rif.row_data} !== e) begin
          n_err++;
          $display("FAIL rstmid_row got %h exp %h",
                   {rif.row_addr, rif.row_data}, e);
        end
      end
      if (gen_ena === 1'b1) g = c;
    end
    n_cmp++;
    if (g == 0 || q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_restart gen %0d left %0d",
               g, q.size());
    end
  endtask

  task automatic test_zero_delay;
    int prev, ngen;
    logic [1:0] ea;
    logic [5:0] e;
    do_reset();
    board = 16'hA5C3;
    run2 = 1'b1;
    prev = 0;
    ngen = 0;
    ea = 2'd0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (rif2.row_valid && rif2.row_ready) begin
        e = {ea, board[ea*4 +: 4]};
        n_cmp++;
        if ({rif2.row_addr, rif2.row_data} !== e) begin
          n_err++;
          $display("FAIL zero_row got %h exp %h",
                   {rif2.row_addr, rif2.row_data}, e);
        end
        ea++;
      end
      if (gen2 === 1'b1) begin
        if (prev != 0) begin
          n_cmp++;
          if (c - prev != 6) begin
            n_err++;
            $display("FAIL zero_period got %0d exp 6",
                     c - prev);
          end
        end
        prev = c;
        ngen++;
      end
    end
    n_cmp++;
    if (ngen != 6) begin
      n_err++;
      $display("FAIL zero_gen_count got %0d exp 6", ngen);
    end
    run2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    run2 = 1'b0;
    board = 16'h0;
    rif.row_ready = 1'b1;
    rif2.row_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_coherence();
    test_run_drop();
    test_reset_mid();
    test_zero_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
